accum_feeder: RTL and testbench

Operand sequencer that drives the accumulator's input side. Operands are captured into a small on-chip FIFO; on a start pulse the block replays them one by one on `acc_data`, issues a single-cycle `acc_enable` strobe per operand, then one `acc_read` strobe so the accumulator's output register captures the final sum. It replaces the debounced push-button and manual read switch with a deterministic, clocked initiator in the same clock domain as the accumulator.

---
 rtl/accum_feeder_pkg.sv | 15 +
 rtl/accum_feeder_operand_fifo.sv | 50 +++++
 rtl/accum_feeder.sv | 93 +++++++++
 tb/tb_accum_feeder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_feeder_pkg.sv
// rtl/accum_feeder_pkg.sv - shared types and constants for the accumulator operand feeder
package accum_feeder_pkg;

  // Matches the accumulator's data path width.
  localparam int DEFAULT_WORD_LENGTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    STROBE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/accum_feeder_operand_fifo.sv
// rtl/accum_feeder_operand_fifo.sv - operand FIFO with registered head read and occupancy count
module operand_fifo
  import accum_feeder_pkg::*;
#(
  parameter int Word_Length = DEFAULT_WORD_LENGTH,
  parameter int Depth       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [Word_Length-1:0]       wr_data,
  input  logic                         rd,
  input  logic                         pop,
  output logic [Word_Length-1:0]       rd_data,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  logic [Word_Length-1:0] mem [Depth];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // A read issued together with a pop fetches the entry behind the one leaving.
      if (rd) rd_data <= pop ? mem[rd_ptr + PW'(1)] : mem[rd_ptr];
      if (wr && !pop) count <= count + CW'(1);
      else if (pop && !wr) count <= count - CW'(1);
    end
  end

  assign full  = (count == CW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/accum_feeder.sv
// rtl/accum_feeder.sv - replays buffered operands into the accumulator with enable/read strobes
module accum_feeder
  import accum_feeder_pkg::*;
#(
  parameter int Word_Length = DEFAULT_WORD_LENGTH,
  parameter int Depth       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [Word_Length-1:0]       data_in,
  input  logic                         start,
  output logic [Word_Length-1:0]       acc_data,
  output logic                         acc_enable,
  output logic                         acc_read,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(Depth+1);

  state_t state, state_next;
  logic   fifo_wr, fifo_rd, fifo_pop;

  operand_fifo #(
    .Word_Length(Word_Length),
    .Depth      (Depth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (fifo_wr),
    .wr_data(data_in),
    .rd     (fifo_rd),
    .pop    (fifo_pop),
    .rd_data(acc_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_next = state;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        // start takes priority; a load arriving with it is dropped.
        if (start) begin
          if (!empty) begin
            state_next = PRESENT;
            fifo_rd    = 1'b1;
          end
        end else if (load && !full) begin
          fifo_wr = 1'b1;
        end
      end
      PRESENT: state_next = STROBE;
      STROBE: begin
        fifo_pop = 1'b1;
        if (count == CW'(1)) begin
          state_next = READ;
        end else begin
          state_next = PRESENT;
          fifo_rd    = 1'b1;
        end
      end
      READ:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc_enable <= 1'b0;
      acc_read   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      acc_enable <= (state_next == STROBE);
      acc_read   <= (state_next == READ);
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_accum_feeder.sv
// tb/tb_accum_feeder.sv - directed self-checking bench for accum_feeder
module tb_accum_feeder;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       start;
  logic [7:0] acc_data;
  logic       acc_enable;
  logic       acc_read;
  logic       busy;
  logic       done;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int vectors;
  int miscompares;

  accum_feeder #(.Word_Length(8), .Depth(4)) dut (
    .clk       (clk),
    .reset     (rst),
    .load      (load),
    .data_in   (data_in),
    .start     (start),
    .acc_data  (acc_data),
    .acc_enable(acc_enable),
    .acc_read  (acc_read),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model plus strobe log, sampled at each rising edge.
  int         cyc;
  logic [7:0] acc_sum;
  logic [7:0] acc_out;
  logic [7:0] en_val[$];
  int         en_cyc[$];
  int         rd_cnt, rd_cyc, done_cnt, done_cyc, busy_cnt;

  initial begin
    cyc = 0; acc_sum = 0; acc_out = 0;
    rd_cnt = 0; rd_cyc = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      acc_sum = 0; acc_out = 0;
      en_val.delete(); en_cyc.delete();
      rd_cnt = 0; rd_cyc = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (acc_enable) begin
        acc_sum = acc_sum + acc_data;
        en_val.push_back(acc_data);
        en_cyc.push_back(cyc);
      end
      if (acc_read) begin
        acc_out = acc_sum;
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        acc_sum = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    data_in = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && done_cnt == 0; i++) tick();
  endtask

  int k;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; load = 1'b0; start = 1'b0; data_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_acc_data", acc_data, 0);
    check("rst_acc_enable", acc_enable, 0);
    check("rst_acc_read", acc_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst = 1'b0;
    tick();

    // 3, 5, 7 replay with exact strobe timing
    do_load(8'd3); do_load(8'd5); do_load(8'd7);
    check("t1_count", count, 3);
    do_start();
    k = cyc;
    check("t1_busy_rise", busy, 1);
    check("t1_present_data", acc_data, 3);
    check("t1_present_no_en", acc_enable, 0);
    wait_done();
    check("t1_done_seen", done_cnt, 1);
    check("t1_n_enables", en_val.size(), 3);
    check("t1_val0", en_val[0], 3);
    check("t1_val1", en_val[1], 5);
    check("t1_val2", en_val[2], 7);
    check("t1_cyc0", en_cyc[0], k + 2);
    check("t1_cyc1", en_cyc[1], k + 4);
    check("t1_cyc2", en_cyc[2], k + 6);
    check("t1_read_cyc", rd_cyc, k + 7);
    check("t1_done_cyc", done_cyc, k + 8);
    check("t1_sum", acc_out, 15);
    check("t1_busy_len", busy_cnt, 8);
    check("t1_empty", empty, 1);

    // Full FIFO drops the fifth load
    do_reset();
    do_load(8'd1); do_load(8'd2); do_load(8'd3); do_load(8'd4); do_load(8'd9);
    check("t2_count", count, 4);
    check("t2_full", full, 1);
    do_start();
    wait_done();
    check("t2_n_enables", en_val.size(), 4);
    check("t2_last_val", en_val[3], 4);
    check("t2_sum", acc_out, 10);
    check("t2_busy_len", busy_cnt, 10);

    // start while empty is ignored
    do_reset();
    do_start();
    check("t3_busy", busy, 0);
    repeat (6) tick();
    check("t3_enables", en_val.size(), 0);
    check("t3_reads", rd_cnt, 0);
    check("t3_dones", done_cnt, 0);
    check("t3_busy_cnt", busy_cnt, 0);

    // Sum wraps in the accumulator, not here
    do_reset();
    do_load(8'd200); do_load(8'd100);
    do_start();
    wait_done();
    check("t4_sum_wrap", acc_out, 44);
    tick();
    check("t4_count", count, 0);
    check("t4_empty", empty, 1);

    // load with start, and load while busy, are both dropped
    do_reset();
    do_load(8'd10); do_load(8'd20);
    load = 1'b1; data_in = 8'd99; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check("t5_count_hold", count, 2);
    do_load(8'd50);
    wait_done();
    tick();
    check("t5_n_enables", en_val.size(), 2);
    check("t5_val0", en_val[0], 10);
    check("t5_val1", en_val[1], 20);
    check("t5_sum", acc_out, 30);
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);

    // Reset in the second STROBE of three
    do_reset();
    do_load(8'd1); do_load(8'd2); do_load(8'd3);
    do_start();
    tick();
    tick();
    tick();
    check("t6_in_strobe2", acc_enable, 1);
    rst = 1'b1;
    #1;
    check("t6_en_drop", acc_enable, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_data_clr", acc_data, 0);
    check("t6_count_clr", count, 0);
    check("t6_empty", empty, 1);
    tick();
    rst = 1'b0;
    do_start();
    check("t6_start_ignored", busy, 0);
    repeat (6) tick();
    check("t6_no_enables", en_val.size(), 0);
    check("t6_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
